// File: rtl/mux_serial_sequencer_pkg.sv
// Shared definitions for the mux serial sequencer: state encoding, widths, Sel mapping.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mux_seq_defs;

   localparam int WORD_W = 4;
   localparam int SEL_W  = 2;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_SHIFT  = 2'd1,
      S_PARITY = 2'd2,
      S_GAP    = 2'd3
   } state_e;

   // Bit index k maps to Sel = k (LSB first) or Sel = 3-k (MSB first).
   function automatic logic [SEL_W-1:0] map_sel(input logic [SEL_W-1:0] idx,
                                                input logic             msb_first);
      return msb_first ? ~idx : idx;
   endfunction

endpackage

// File: rtl/mux_serial_sequencer_sel_index_counter.sv
// Bit-index counter that drives a registered, glitch-free Sel with MSB_FIRST ordering.
// Latency: Sel for the next index is valid the cycle after start/step.
// Backpressure: none; the controlling FSM decides when to start, step, hold or park.
module sel_index_counter
   import mux_seq_defs::*;
#(
   parameter bit MSB_FIRST = 1'b0
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             start_i,
   input  logic             step_i,
   input  logic             park_i,
   output logic [SEL_W-1:0] sel_o,
   output logic             last_o
);

   logic [SEL_W-1:0] idx_q, idx_d;
   logic [SEL_W-1:0] sel_q, sel_d;

   // Next index: park returns Sel to 0, start loads index 0, step advances; otherwise hold.
   always_comb begin
      idx_d = idx_q;
      sel_d = sel_q;
      if (park_i) begin
         idx_d = '0;
         sel_d = '0;
      end else if (start_i) begin
         idx_d = '0;
         sel_d = map_sel(idx_d, MSB_FIRST);
      end else if (step_i) begin
         idx_d = idx_q + 1'b1;
         sel_d = map_sel(idx_d, MSB_FIRST);
      end
   end

   // Index and Sel registers.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         idx_q <= '0;
         sel_q <= '0;
      end else begin
         idx_q <= idx_d;
         sel_q <= sel_d;
      end
   end

   assign sel_o  = sel_q;
   assign last_o = &idx_q;

endmodule

// File: rtl/mux_serial_sequencer.sv
// Serializes a 4-bit word through an external 4:1 mux into a framed bit stream; MUX_SEQ_PARITY_EN appends even parity.
// Latency: first serial bit two cycles after the accepting edge; frame period 5+GAP cycles (6+GAP with parity).
// Backpressure: In_Ready is high only in IDLE; In_Valid/In_Data are ignored while busy.
module mux_serial_sequencer
   import mux_seq_defs::*;
#(
   parameter bit          MSB_FIRST = 1'b0,
   parameter int unsigned GAP       = 0
) (
   input  logic              CLK,
   input  logic              RESET,
   input  logic [WORD_W-1:0] In_Data,
   input  logic              In_Valid,
   output logic              In_Ready,
   output logic [WORD_W-1:0] Mux_In,
   output logic [SEL_W-1:0]  Sel,
   input  logic              Mux_Out,
   output logic              Ser_Out,
   output logic              Ser_Valid,
   output logic              Ser_Last,
   output logic              Busy
);

   localparam logic [3:0] GAP_LAST    = (GAP > 0) ? 4'(GAP - 1) : 4'd0;
   localparam state_e     AFTER_FRAME = (GAP > 0) ? S_GAP : S_IDLE;

   state_e            state_q, state_d;
   logic [3:0]        gap_q, gap_d;
   logic [WORD_W-1:0] mux_in_q, mux_in_d;
   logic              ser_out_q, ser_out_d;
   logic              ser_vld_q, ser_vld_d;
   logic              ser_last_q, ser_last_d;
   logic              cnt_start, cnt_step, cnt_park, idx_last;

   sel_index_counter #(.MSB_FIRST(MSB_FIRST)) u_sel_cnt (
      .clk_i   (CLK),
      .rst_i   (RESET),
      .start_i (cnt_start),
      .step_i  (cnt_step),
      .park_i  (cnt_park),
      .sel_o   (Sel),
      .last_o  (idx_last)
   );

   // Next state, word latch, serial output register inputs and Sel counter control.
   always_comb begin
      state_d    = state_q;
      gap_d      = gap_q;
      mux_in_d   = mux_in_q;
      ser_out_d  = 1'b0;
      ser_vld_d  = 1'b0;
      ser_last_d = 1'b0;
      cnt_start  = 1'b0;
      cnt_step   = 1'b0;
      cnt_park   = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (In_Valid) begin
               mux_in_d  = In_Data;
               cnt_start = 1'b1;
               state_d   = S_SHIFT;
            end
         end
         S_SHIFT: begin
            // The mux bit for the Sel shown this cycle becomes next cycle's serial bit.
            ser_out_d = Mux_Out;
            ser_vld_d = 1'b1;
            if (!idx_last) begin
               cnt_step = 1'b1;
            end else begin
`ifdef MUX_SEQ_PARITY_EN
               // Sel holds its last value through the parity cycle.
               state_d = S_PARITY;
`else
               ser_last_d = 1'b1;
               cnt_park   = 1'b1;
               gap_d      = '0;
               state_d    = AFTER_FRAME;
`endif
            end
         end
         S_PARITY: begin
`ifdef MUX_SEQ_PARITY_EN
            ser_out_d  = ^mux_in_q;
            ser_vld_d  = 1'b1;
            ser_last_d = 1'b1;
            cnt_park   = 1'b1;
            gap_d      = '0;
            state_d    = AFTER_FRAME;
`else
            cnt_park = 1'b1;
            state_d  = S_IDLE;
`endif
         end
         S_GAP: begin
            if (gap_q == GAP_LAST) begin
               gap_d   = '0;
               state_d = S_IDLE;
            end else begin
               gap_d = gap_q + 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State, gap counter, word latch and serial output registers.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q    <= S_IDLE;
         gap_q      <= '0;
         mux_in_q   <= '0;
         ser_out_q  <= 1'b0;
         ser_vld_q  <= 1'b0;
         ser_last_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         gap_q      <= gap_d;
         mux_in_q   <= mux_in_d;
         ser_out_q  <= ser_out_d;
         ser_vld_q  <= ser_vld_d;
         ser_last_q <= ser_last_d;
      end
   end

   assign In_Ready  = (state_q == S_IDLE);
   assign Busy      = (state_q != S_IDLE);
   assign Mux_In    = mux_in_q;
   assign Ser_Out   = ser_out_q;
   assign Ser_Valid = ser_vld_q;
   assign Ser_Last  = ser_last_q;

endmodule

// File: tb/tb_mux_serial_sequencer.sv
// Bench for mux_serial_sequencer: two configurations (LSB-first/no gap, MSB-first/gap 2) run in parallel.
// Each has a frame-level reference model feeding scoreboard queues, checked by a per-cycle monitor.
// Stimulus mixes directed words, back-to-back transfers, resets and random words.
`timescale 1ns/1ps
module tb_mux_serial_sequencer;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int errors   = 0;
   int checks   = 0;
   int done_cnt = 0;

`ifdef MUX_SEQ_PARITY_EN
   localparam int P = 1;
`else
   localparam int P = 0;
`endif

   typedef struct {
      int c;
      int v;
      int last;
   } exp_t;

   task automatic check(input int cfg, input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL cfg%0d %s: got %0d, expected %0d (cycle %0d)", cfg, name, act, exp, cyc);
      end
   endtask

   for (genvar g = 0; g < 2; g++) begin : cfg
      localparam bit MSB    = (g == 1);
      localparam int G      = (g == 1) ? 2 : 0;
      localparam int PERIOD = 5 + P + G;

      logic       rst = 1'b1;
      logic [3:0] in_data = '0;
      logic       in_valid = 1'b0;
      logic       in_ready, ser_out, ser_valid, ser_last, busy, mux_out;
      logic [3:0] mux_in;
      logic [1:0] sel;

      mux_serial_sequencer #(.MSB_FIRST(MSB), .GAP(G)) dut (
         .CLK       (clk),
         .RESET     (rst),
         .In_Data   (in_data),
         .In_Valid  (in_valid),
         .In_Ready  (in_ready),
         .Mux_In    (mux_in),
         .Sel       (sel),
         .Mux_Out   (mux_out),
         .Ser_Out   (ser_out),
         .Ser_Valid (ser_valid),
         .Ser_Last  (ser_last),
         .Busy      (busy)
      );

      // The external 4:1 mux.
      assign mux_out = mux_in[sel];

      exp_t       ser_q[$];
      exp_t       sel_q[$];
      logic [3:0] exp_mux  = '0;
      int         busy_end = -1;
      bit         mon_on   = 1'b0;
      int         last_acc = -1;

      // Frame model: word accepted at the edge ending cycle n.
      task automatic model_accept(input int n, input logic [3:0] w);
         int idx = 0;
         for (int k = 0; k < 4; k++) begin
            idx = MSB ? 3 - k : k;
            sel_q.push_back('{n + 1 + k, idx, 0});
            ser_q.push_back('{n + 2 + k, int'(w[idx]), (k == 3 && P == 0) ? 1 : 0});
         end
         if (P == 1) begin
            sel_q.push_back('{n + 5, idx, 0});
            ser_q.push_back('{n + 6, int'(^w), 1});
         end
         exp_mux  = w;
         busy_end = n + 4 + P + G;
      endtask

      // Reset sampled at the edge ending cycle n: everything later is abandoned.
      task automatic model_reset(input int n);
         while (ser_q.size() > 0 && ser_q[$].c > n) ser_q.pop_back();
         while (sel_q.size() > 0 && sel_q[$].c > n) sel_q.pop_back();
         exp_mux  = '0;
         busy_end = n;
      endtask

      task automatic idle(input int k);
         repeat (k) begin
            in_valid = 1'b0;
            in_data  = 4'($urandom);
            @(posedge clk); #1;
         end
      endtask

      task automatic send(input logic [3:0] w, input bit b2b);
         bit ok = 1'b0;
         in_data  = w;
         in_valid = 1'b1;
         for (int t = 0; t < 40 && !ok; t++) begin
            @(negedge clk); #1;
            if (in_ready) begin
               ok = 1'b1;
               model_accept(cyc, w);
               if (b2b && last_acc >= 0) check(g, "b2b_period", cyc - last_acc, PERIOD);
               last_acc = cyc;
            end
         end
         check(g, "handshake_seen", int'(ok), 1);
         @(posedge clk); #1;
         in_valid = 1'b0;
      endtask

      task automatic pulse_reset(input int n, input logic vld);
         rst      = 1'b1;
         in_valid = vld;
         in_data  = 4'hF;
         repeat (n) begin
            @(negedge clk); #1;
            model_reset(cyc);
            @(posedge clk); #1;
         end
         rst      = 1'b0;
         in_valid = 1'b0;
      endtask

      // Monitor: compare every cycle against the scoreboard.
      always @(negedge clk) begin : mon
         int es;
         int eb;
         if (mon_on) begin
            es = 0;
            if (sel_q.size() > 0 && sel_q[0].c == cyc) begin
               es = sel_q[0].v;
               void'(sel_q.pop_front());
            end
            check(g, "sel", int'(sel), es);
            if (ser_q.size() > 0 && ser_q[0].c == cyc) begin
               check(g, "ser_valid", int'(ser_valid), 1);
               check(g, "ser_out", int'(ser_out), ser_q[0].v);
               check(g, "ser_last", int'(ser_last), ser_q[0].last);
               void'(ser_q.pop_front());
            end else begin
               check(g, "ser_valid_idle", int'(ser_valid), 0);
               check(g, "ser_last_idle", int'(ser_last), 0);
            end
            eb = (cyc <= busy_end) ? 1 : 0;
            check(g, "busy", int'(busy), eb);
            check(g, "in_ready", int'(in_ready), 1 - eb);
            check(g, "mux_in", int'(mux_in), int'(exp_mux));
         end
      end

      initial begin : stim
         bit b2b;
         pulse_reset(2, 1'b1);
         mon_on = 1'b1;
         @(negedge clk); #1;
         check(g, "reset_ser_out", int'(ser_out), 0);
         @(posedge clk); #1;

         send(4'b1011, 1'b0);
         idle(6);
         send(4'hA, 1'b0);
         send(4'h5, 1'b1);
         idle(8);

         // Reset during c2 of a frame.
         send(4'b0110, 1'b0);
         @(posedge clk); #1;
         pulse_reset(1, 1'b0);
         idle(2);
         send(4'b0111, 1'b0);
         idle(6);

         b2b = 1'b0;
         repeat (25) begin
            send(4'($urandom), b2b);
            b2b = ($urandom_range(0, 1) == 1);
            if (!b2b) idle($urandom_range(1, 3));
         end
         idle(12);
         check(g, "ser_drained", ser_q.size(), 0);
         check(g, "sel_drained", sel_q.size(), 0);
         done_cnt++;
      end
   end

   initial begin
      wait (done_cnt == 2);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      errors++;
      $display("FAIL watchdog: bench did not complete, done=%0d expected 2", done_cnt);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $fatal(1, "watchdog expired");
   end

endmodule
